// File: rtl/sipo_defs.sv
// Shared definitions for the sipo_deser receiver: FSM state encoding and
// the ceiling-log2 helper used to size the bit counter.
package sipo_defs;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest r with 2**r >= value; sizes a counter that holds 0..value-1.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter. next_word is the word as it would look
// with the current serial bit included, so the parent can capture a
// finished word on the same edge that samples its last bit.
module sipo_shift_core #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             msb_first,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             serial_bit,
    output logic [WIDTH-1:0] next_word,
    output logic             last_bit,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [WIDTH-1:0] shreg;

    // Candidate word including the incoming bit, in the selected bit order.
    always_comb begin
        next_word = '0;
        if (msb_first) next_word = {shreg[WIDTH-2:0], serial_bit};
        else           next_word = {serial_bit, shreg[WIDTH-1:1]};
    end

    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    // Accumulate bits; a finished word or a clear leaves the core empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            if (last_bit) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg   <= next_word;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out frame receiver. Owns the IDLE/SHIFT FSM, the
// output word register with its handshake, and the error flags.
//
// Handshake: out/out_valid form a valid/ready pair. A word transfers on
// any rising edge where out_valid=1 and out_ready=1. While out_valid=1,
// out is held stable. A word completing while out_valid=1 and
// out_ready=0 is dropped and sets the sticky overrun flag.
//
// busy is the registered FSM state (1 = SHIFT) and doubles as the state
// observation point.
module sipo_deser
    import sipo_defs::*;
#(
    parameter int   WIDTH     = 4,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  CNT_W     = clog2_f(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_series,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_err,
    output logic             overrun
);

    state_t           state;
    logic [WIDTH-1:0] next_word;
    logic             last_bit;
    logic             in_shift;
    logic             complete;
    logic             abort;
    logic             shift_en;
    logic             clear;

    assign in_shift = (state == SHIFT);
    // Completion outranks a coincident start: the word is kept, no error.
    assign complete = in_shift && in_valid && last_bit;
    assign abort    = in_shift && start && !complete;
    // A bit arriving with an aborting start is discarded.
    assign shift_en = in_shift && in_valid && !abort;
    assign clear    = abort || (!in_shift && start);

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (reset),
        .msb_first  (MSB_FIRST),
        .shift_en   (shift_en),
        .clear      (clear),
        .serial_bit (in_series),
        .next_word  (next_word),
        .last_bit   (last_bit),
        .bit_cnt    (bit_cnt)
    );

    // FSM, output register/handshake and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= abort;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // start on the completion edge opens the next frame.
                    if (complete && !start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (complete) begin
                if (!out_valid || out_ready) begin
                    out       <= next_word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: one MSB-first and one LSB-first instance share the
// same stimulus; each has its own expected-word queue.
module tb_sipo_deser;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_series;
    logic       in_valid;
    logic       out_ready;

    logic [3:0] m_out, l_out;
    logic       m_out_valid, l_out_valid;
    logic       m_busy, l_busy;
    logic [1:0] m_bit_cnt, l_bit_cnt;
    logic       m_frame_err, l_frame_err;
    logic       m_overrun, l_overrun;

    logic [3:0] exp_msb_q[$];
    logic [3:0] exp_lsb_q[$];

    int total;
    int bad;
    int ferr_pulses;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_series (in_series),
        .in_valid  (in_valid),
        .out       (m_out),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .busy      (m_busy),
        .bit_cnt   (m_bit_cnt),
        .frame_err (m_frame_err),
        .overrun   (m_overrun)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_series (in_series),
        .in_valid  (in_valid),
        .out       (l_out),
        .out_valid (l_out_valid),
        .out_ready (out_ready),
        .busy      (l_busy),
        .bit_cnt   (l_bit_cnt),
        .frame_err (l_frame_err),
        .overrun   (l_overrun)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, return 1 time unit after the sampling edge.
    task automatic cyc(input logic st, input logic iv, input logic b);
        start     = st;
        in_valid  = iv;
        in_series = b;
        @(posedge clk);
        #1;
    endtask

    // Start pulse then four contiguous bits, bits[3] sent first.
    task automatic send_word(input logic [3:0] bits);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) cyc(1'b0, 1'b1, bits[i]);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        ferr_pulses = 0;
        reset       = 1'b0;
        start       = 1'b0;
        in_series   = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;

        // Scoreboard monitor and frame_err pulse counter.
        fork
            forever begin
                @(negedge clk);
                if (reset && m_frame_err) ferr_pulses++;
                if (reset && m_out_valid && out_ready) begin
                    if (exp_msb_q.size() == 0) check("msb_unexpected_word", 32'(m_out), 32'hx);
                    else check("msb_word", 32'(m_out), 32'(exp_msb_q.pop_front()));
                end
                if (reset && l_out_valid && out_ready) begin
                    if (exp_lsb_q.size() == 0) check("lsb_unexpected_word", 32'(l_out), 32'hx);
                    else check("lsb_word", 32'(l_out), 32'(exp_lsb_q.pop_front()));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(m_out), 32'h0);
        check("reset_out_valid", 32'(m_out_valid), 32'h0);
        check("reset_busy", 32'(m_busy), 32'h0);
        check("reset_bit_cnt", 32'(m_bit_cnt), 32'h0);
        check("reset_overrun", 32'(m_overrun), 32'h0);
        reset = 1'b1;

        // in_valid without start is ignored.
        cyc(1'b0, 1'b1, 1'b1);
        check("idle_ignore_busy", 32'(m_busy), 32'h0);
        check("idle_ignore_cnt", 32'(m_bit_cnt), 32'h0);

        // Basic frame 1,1,0,1 with consumer ready.
        exp_msb_q.push_back(4'b1101);
        exp_lsb_q.push_back(4'b1011);
        cyc(1'b1, 1'b0, 1'b0);
        check("t1_busy_after_start", 32'(m_busy), 32'h1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check("t1_bit_cnt", 32'(m_bit_cnt), 32'h3);
        cyc(1'b0, 1'b1, 1'b1);
        check("t1_out_valid", 32'(m_out_valid), 32'h1);
        check("t1_busy_falls", 32'(m_busy), 32'h0);
        check("t1_lsb_out", 32'(l_out), 32'hb);
        cyc(1'b0, 1'b0, 1'b0);
        check("t1_out_valid_one_cycle", 32'(m_out_valid), 32'h0);

        // Overrun: consumer stalled, second word 0110 dropped.
        out_ready = 1'b0;
        exp_msb_q.push_back(4'b1101);
        exp_lsb_q.push_back(4'b1011);
        send_word(4'b1101);
        send_word(4'b0110);
        check("t2_overrun", 32'(m_overrun), 32'h1);
        check("t2_lsb_overrun", 32'(l_overrun), 32'h1);
        check("t2_out_held", 32'(m_out), 32'hd);
        check("t2_out_valid_held", 32'(m_out_valid), 32'h1);
        out_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("t2_out_valid_clear", 32'(m_out_valid), 32'h0);
        check("t2_overrun_sticky", 32'(m_overrun), 32'h1);

        // Abort: start, 1,0, start (with a bit that must be dropped), 0,0,1,1.
        exp_msb_q.push_back(4'b0011);
        exp_lsb_q.push_back(4'b1100);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check("t3_cnt_before_abort", 32'(m_bit_cnt), 32'h2);
        cyc(1'b1, 1'b1, 1'b1);
        check("t3_frame_err", 32'(m_frame_err), 32'h1);
        check("t3_cnt_cleared", 32'(m_bit_cnt), 32'h0);
        check("t3_busy_stays", 32'(m_busy), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        check("t3_frame_err_pulse", 32'(m_frame_err), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t3_out", 32'(m_out), 32'h3);
        cyc(1'b0, 1'b0, 1'b0);

        // Back-to-back: start on the completion edge of 1010, then 0101.
        exp_msb_q.push_back(4'b1010);
        exp_lsb_q.push_back(4'b0101);
        exp_msb_q.push_back(4'b0101);
        exp_lsb_q.push_back(4'b1010);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        check("t4_b2b_busy", 32'(m_busy), 32'h1);
        check("t4_b2b_no_ferr", 32'(m_frame_err), 32'h0);
        check("t4_b2b_out", 32'(m_out), 32'ha);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check("t4_second_out", 32'(m_out), 32'h5);
        cyc(1'b0, 1'b0, 1'b0);

        // Gaps: bits 0,1,1,1 on alternate cycles, junk on in_series in gaps.
        exp_msb_q.push_back(4'b0111);
        exp_lsb_q.push_back(4'b1110);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("t5_cnt_hold_1", 32'(m_bit_cnt), 32'h1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t5_cnt_hold_2", 32'(m_bit_cnt), 32'h2);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("t5_busy_in_gap", 32'(m_busy), 32'h1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t5_out", 32'(m_out), 32'h7);
        cyc(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame, then a clean 1001 frame.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        start    = 1'b0;
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_out", 32'(m_out), 32'h0);
        check("t6_rst_out_valid", 32'(m_out_valid), 32'h0);
        check("t6_rst_busy", 32'(m_busy), 32'h0);
        check("t6_rst_cnt", 32'(m_bit_cnt), 32'h0);
        check("t6_rst_overrun", 32'(m_overrun), 32'h0);
        check("t6_rst_lsb_overrun", 32'(l_overrun), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_msb_q.push_back(4'b1001);
        exp_lsb_q.push_back(4'b1001);
        send_word(4'b1001);
        check("t6_out", 32'(m_out), 32'h9);
        check("t6_overrun_clean", 32'(m_overrun), 32'h0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);

        // Final report.
        check("msb_queue_drained", 32'(exp_msb_q.size()), 32'h0);
        check("lsb_queue_drained", 32'(exp_lsb_q.size()), 32'h0);
        check("frame_err_pulses", 32'(ferr_pulses), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
